// File: rtl/vram_write_arbiter_if.sv
// Bus bundle between the VRAM write arbiter and its CPU/clear/VGA clients and the char RAM port.
interface vram_write_arbiter_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 11
) ();

  logic              cpu_we;
  logic [13:0]       cpu_xy;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_busy;
  logic              clr_req;
  logic [DATA_W-1:0] clr_data;
  logic              clr_busy;
  logic              vga_rdn;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_grant;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_din;
  logic              vram_we;
  logic [7:0]        drop_cnt;

  modport slave (
    input  cpu_we, cpu_xy, cpu_data, clr_req, clr_data, vga_rdn, vga_addr,
    output cpu_busy, clr_busy, vga_grant, vram_addr, vram_din, vram_we, drop_cnt
  );

  modport master (
    output cpu_we, cpu_xy, cpu_data, clr_req, clr_data, vga_rdn, vga_addr,
    input  cpu_busy, clr_busy, vga_grant, vram_addr, vram_din, vram_we, drop_cnt
  );

endinterface

// File: rtl/vram_write_arbiter.sv
// Shares the char VRAM port: VGA reads first, then the screen-clear sequencer, then queued CPU writes.
module vram_write_arbiter #(
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned DATA_W     = 11,
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 60,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  vram_write_arbiter_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CELLS = ROWS * COLS;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic [DATA_W-1:0] clr_fill_q;
  wr_entry_t         fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [7:0]        drop_q;

  logic [5:0]        row;
  logic [7:0]        col;
  logic              in_range;
  logic              full;
  logic              push;
  logic              reject;
  logic              pop;
  logic              clr_wr;
  wr_entry_t         push_entry;

  assign row      = bus.cpu_xy[13:8];
  assign col      = bus.cpu_xy[7:0];
  assign in_range = (32'(row) < ROWS) && (32'(col) < COLS);
  // Fullness is judged on the start-of-cycle count, so a same-cycle pop never frees a slot.
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign push     = bus.cpu_we && !full && in_range;
  assign reject   = bus.cpu_we && !push;
  assign clr_wr   = !rst && bus.vga_rdn && (state_q == CLEAR);
  assign pop      = !rst && bus.vga_rdn && (state_q != CLEAR) && (count_q != '0);

  assign push_entry.addr = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  assign push_entry.data = bus.cpu_data;

  assign bus.cpu_busy  = full;
  assign bus.clr_busy  = (state_q == CLEAR);
  assign bus.vga_grant = ~bus.vga_rdn;
  assign bus.drop_cnt  = drop_q;

  // Port mux; the port is held quiet while reset is asserted.
  always_comb begin
    bus.vram_addr = '0;
    bus.vram_din  = '0;
    bus.vram_we   = 1'b0;
    if (!rst) begin
      if (!bus.vga_rdn) begin
        bus.vram_addr = bus.vga_addr;
      end else if (state_q == CLEAR) begin
        bus.vram_addr = clr_ptr_q;
        bus.vram_din  = clr_fill_q;
        bus.vram_we   = 1'b1;
      end else if (count_q != '0) begin
        bus.vram_addr = fifo_q[rd_ptr_q].addr;
        bus.vram_din  = fifo_q[rd_ptr_q].data;
        bus.vram_we   = 1'b1;
      end
    end
  end

  // Queue storage needs no reset: entries are only read while count_q says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      clr_ptr_q  <= '0;
      clr_fill_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_q     <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (reject && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;

      case (state_q)
        IDLE: begin
          if (bus.clr_req) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            clr_fill_q <= bus.clr_data;
          end
        end
        CLEAR: begin
          if (clr_wr) begin
            if (clr_ptr_q == ADDR_W'(CELLS - 1)) begin
              state_q   <= IDLE;
              clr_ptr_q <= '0;
            end else begin
              clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Scoreboard bench for vram_write_arbiter: every VRAM write is matched against an expected-write queue.
module tb_vram_write_arbiter;

  typedef struct packed {
    logic [12:0] addr;
    logic [10:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t exp_q[$];
  exp_t mon_e;

  vram_write_arbiter_if #(.ADDR_W(13), .DATA_W(11)) bus ();

  vram_write_arbiter #(
    .ADDR_W(13), .DATA_W(11), .COLS(80), .ROWS(60), .FIFO_DEPTH(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: VGA priority and in-order retirement of every write.
  always @(negedge clk) begin
    if (!rst && bus.vga_rdn === 1'b0) begin
      total++;
      if (bus.vram_we !== 1'b0 || bus.vram_addr !== bus.vga_addr || bus.vga_grant !== 1'b1) begin
        bad++;
        $display("FAIL vga_priority: we=%0b addr=%0d grant=%0b, want we=0 addr=%0d grant=1",
                 bus.vram_we, bus.vram_addr, bus.vga_grant, bus.vga_addr);
      end
    end
    if (bus.vram_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr=%0d din=%h at %0t", bus.vram_addr, bus.vram_din, $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.vram_addr !== mon_e.addr || bus.vram_din !== mon_e.data) begin
          bad++;
          $display("FAIL write_content: addr=%0d din=%h, want addr=%0d din=%h",
                   bus.vram_addr, bus.vram_din, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.cpu_we = 1'b0; bus.cpu_xy = '0; bus.cpu_data = '0;
    bus.clr_req = 1'b0; bus.clr_data = '0;
    bus.vga_rdn = 1'b1; bus.vga_addr = '0;
    cycle(); cycle();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.cpu_busy, bus.clr_busy, bus.vram_we, bus.vram_addr, bus.vram_din, bus.drop_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_state: busy=%0b clr=%0b we=%0b addr=%0d din=%h drop=%0d, want all 0",
               bus.cpu_busy, bus.clr_busy, bus.vram_we, bus.vram_addr, bus.vram_din, bus.drop_cnt);
    end
  endtask

  task automatic test_single_write();
    cycle();
    bus.cpu_we = 1'b1; bus.cpu_xy = {6'd2, 8'd5}; bus.cpu_data = 11'h123;
    exp_q.push_back({13'd165, 11'h123});
    @(negedge clk);
    total++;
    if (bus.vram_we !== 1'b0) begin
      bad++; $display("FAIL single_early: we=%0b want 0", bus.vram_we);
    end
    cycle();
    bus.cpu_we = 1'b0;
    @(negedge clk);
    total++;
    if (bus.vram_we !== 1'b1) begin
      bad++; $display("FAIL single_retire: we=%0b want 1", bus.vram_we);
    end
    cycle();
    @(negedge clk);
    total++;
    if (bus.vram_we !== 1'b0) begin
      bad++; $display("FAIL single_after: we=%0b want 0", bus.vram_we);
    end
  endtask

  task automatic test_fifo_full();
    cycle();
    bus.vga_rdn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.cpu_busy !== (i == 4)) begin
        bad++; $display("FAIL fifo_busy_%0d: busy=%0b want %0b", i, bus.cpu_busy, (i == 4));
      end
      bus.vga_addr = 13'(1000 + 37 * i);
      bus.cpu_we   = 1'b1;
      bus.cpu_xy   = {6'(10 + i), 8'(3 * i)};
      bus.cpu_data = 11'(100 + i);
      if (i < 4) exp_q.push_back({13'((10 + i) * 80 + 3 * i), 11'(100 + i)});
      cycle();
    end
    bus.cpu_we = 1'b0;
    total++;
    if (bus.drop_cnt !== 8'd1) begin
      bad++; $display("FAIL fifo_drop: drop=%0d want 1", bus.drop_cnt);
    end
    bus.vga_rdn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (bus.vram_we !== 1'b1) begin
        bad++; $display("FAIL fifo_drain_%0d: we=%0b want 1", k, bus.vram_we);
      end
      cycle();
    end
    @(negedge clk);
    total++;
    if (bus.vram_we !== 1'b0 || bus.cpu_busy !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL fifo_empty: we=%0b busy=%0b pending=%0d want 0 0 0",
               bus.vram_we, bus.cpu_busy, exp_q.size());
    end
  endtask

  task automatic test_range();
    logic [13:0] bad_xy [3];
    int n;
    bad_xy[0] = {6'd0, 8'd80};
    bad_xy[1] = {6'd60, 8'd0};
    bad_xy[2] = {6'd63, 8'd255};
    cycle();
    for (int i = 0; i < 3; i++) begin
      bus.cpu_we = 1'b1; bus.cpu_xy = bad_xy[i]; bus.cpu_data = 11'h7AA;
      cycle();
    end
    bus.cpu_we = 1'b0;
    total++;
    if (bus.drop_cnt !== 8'd4 || bus.cpu_busy !== 1'b0) begin
      bad++; $display("FAIL range_drop: drop=%0d busy=%0b want 4 0", bus.drop_cnt, bus.cpu_busy);
    end
    bus.cpu_we = 1'b1; bus.cpu_xy = {6'd59, 8'd79}; bus.cpu_data = 11'h2AA;
    exp_q.push_back({13'd4799, 11'h2AA});
    cycle();
    bus.cpu_xy = {6'd0, 8'd0}; bus.cpu_data = 11'h001;
    exp_q.push_back({13'd0, 11'h001});
    cycle();
    bus.cpu_we = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin cycle(); n++; end
    total++;
    if (exp_q.size() != 0 || bus.drop_cnt !== 8'd4) begin
      bad++; $display("FAIL range_edge: pending=%0d drop=%0d want 0 4", exp_q.size(), bus.drop_cnt);
    end
  endtask

  task automatic test_clear(input bit alt);
    int n;
    cycle();
    bus.vga_rdn = 1'b1;
    bus.clr_req = 1'b1; bus.clr_data = 11'h020;
    for (int a = 0; a < 4800; a++) exp_q.push_back({13'(a), 11'h020});
    cycle();
    bus.clr_req = 1'b0;
    n = 0;
    while (bus.clr_busy === 1'b1 && n < 20000) begin
      n++;
      bus.clr_req  = (n == 1000);
      bus.clr_data = (n == 1000) ? 11'h555 : 11'h020;
      if (alt) begin
        bus.vga_rdn  = (n % 2 == 0);
        bus.vga_addr = 13'($urandom_range(0, 8191));
      end
      cycle();
    end
    bus.clr_req = 1'b0; bus.vga_rdn = 1'b1;
    total++;
    if (n != (alt ? 9600 : 4800) || exp_q.size() != 0) begin
      bad++; $display("FAIL clear_len_alt%0b: busy_cycles=%0d pending=%0d want %0d 0",
                      alt, n, exp_q.size(), alt ? 9600 : 4800);
    end
  endtask

  task automatic test_clear_then_cpu();
    int n;
    cycle();
    bus.clr_req = 1'b1; bus.clr_data = 11'h3C3;
    for (int a = 0; a < 4800; a++) exp_q.push_back({13'(a), 11'h3C3});
    cycle();
    bus.clr_req = 1'b0;
    for (int k = 0; k < 5; k++) cycle();
    bus.cpu_we = 1'b1; bus.cpu_xy = {6'd0, 8'd3}; bus.cpu_data = 11'h7FF;
    exp_q.push_back({13'd3, 11'h7FF});
    cycle();
    bus.cpu_we = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 6000) begin cycle(); n++; end
    total++;
    if (exp_q.size() != 0 || bus.clr_busy !== 1'b0) begin
      bad++; $display("FAIL clear_cpu_order: pending=%0d clr_busy=%0b want 0 0", exp_q.size(), bus.clr_busy);
    end
  endtask

  task automatic test_reset_mid_clear();
    cycle();
    bus.clr_req = 1'b1; bus.clr_data = 11'h1AA;
    for (int a = 0; a < 100; a++) exp_q.push_back({13'(a), 11'h1AA});
    cycle();
    bus.clr_req = 1'b0;
    for (int k = 0; k < 100; k++) begin
      bus.cpu_we = (k < 3); bus.cpu_xy = {6'd1, 8'(k)}; bus.cpu_data = 11'(k);
      cycle();
    end
    bus.cpu_we = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    total++;
    if (bus.clr_busy !== 1'b0 || bus.cpu_busy !== 1'b0 || bus.drop_cnt !== 8'd0 || exp_q.size() != 0) begin
      bad++; $display("FAIL reset_mid: clr=%0b busy=%0b drop=%0d pending=%0d want 0 0 0 0",
                      bus.clr_busy, bus.cpu_busy, bus.drop_cnt, exp_q.size());
    end
    @(negedge clk);
    total++;
    if (bus.vram_we !== 1'b0) begin
      bad++; $display("FAIL reset_mid_we: we=%0b want 0", bus.vram_we);
    end
    for (int k = 0; k < 10; k++) cycle();
    for (int i = 0; i < 300; i++) begin
      if (i == 254) begin
        total++;
        if (bus.drop_cnt !== 8'd254) begin
          bad++; $display("FAIL drop_254: drop=%0d want 254", bus.drop_cnt);
        end
      end
      bus.cpu_we = 1'b1; bus.cpu_xy = {6'd0, 8'd200}; bus.cpu_data = 11'h0;
      cycle();
    end
    bus.cpu_we = 1'b0;
    total++;
    if (bus.drop_cnt !== 8'd255) begin
      bad++; $display("FAIL drop_sat: drop=%0d want 255", bus.drop_cnt);
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_write();
    test_fifo_full();
    test_range();
    test_clear(1'b0);
    test_clear(1'b1);
    test_clear_then_cpu();
    test_reset_mid_clear();
    cycle(); cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
